// File: rtl/nbit_serial_addsub.sv
// nbit_serial_addsub: multi-cycle N-bit add/subtract, CHUNK bits per cycle, LSB chunk first.
// Define NBIT_ADDSUB_SAT_EN to clamp the result to the signed range on overflow.
module nbit_serial_addsub #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic         cout,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);
    localparam int NC = N / CHUNK;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next_state;
    logic [N-1:0]     r_a, r_b, r_y;
    logic             r_carry, r_cout, r_ovf, r_zero, r_neg;
    logic [CW-1:0]    r_cnt;
    int               w_base;
    logic [CHUNK-1:0] w_a_ch, w_b_ch;
    logic [CHUNK:0]   w_sum;
    logic             w_cin_msb, w_ovf, w_last;
    logic [N-1:0]     w_y_next, w_y_fin;

    always_comb begin
        w_next_state = r_state;
        in_ready     = r_state == IDLE;
        out_valid    = r_state == DONE;
        if (r_state == IDLE && in_valid)
            w_next_state = RUN;
        else if (r_state == RUN && w_last)
            w_next_state = DONE;
        else if (r_state == DONE && out_ready)
            w_next_state = IDLE;
    end

    always_comb begin
        w_base    = int'(r_cnt) * CHUNK;
        w_a_ch    = r_a[w_base +: CHUNK];
        w_b_ch    = r_b[w_base +: CHUNK];
        w_sum     = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
        // sum bit = a ^ b ^ cin, so the carry into the top bit falls out without a second adder
        w_cin_msb = w_sum[CHUNK-1] ^ w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1];
        w_ovf     = w_cin_msb ^ w_sum[CHUNK];
        w_last    = r_cnt == CW'(NC - 1);
        w_y_next  = r_y;
        w_y_next[w_base +: CHUNK] = w_sum[CHUNK-1:0];
`ifdef NBIT_ADDSUB_SAT_EN
        // a wrapped result carries the wrong sign, so its MSB picks the opposite rail
        w_y_fin   = w_ovf ? (w_y_next[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}}) : w_y_next;
`else
        w_y_fin   = w_y_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && in_valid) begin
                r_a     <= A;
                r_b     <= B ^ {N{sub}};
                r_carry <= sub;
                r_cnt   <= '0;
            end
            if (r_state == RUN) begin
                r_carry <= w_sum[CHUNK];
                r_cnt   <= r_cnt + 1'b1;
                r_y     <= w_last ? w_y_fin : w_y_next;
                if (w_last) begin
                    r_cout <= w_sum[CHUNK];
                    r_ovf  <= w_ovf;
                    r_zero <= w_y_fin == '0;
                    r_neg  <= w_y_fin[N-1];
                end
            end
        end
    end

    assign Y        = r_y;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;
    assign negative = r_neg;
endmodule
